// File: rtl/spi_link_pair.sv
// spi_link_pair: SPI mode-0 master and slave sharing one clock, joined by
// internal SCLK/SS_N/MOSI/MISO nets. Each transfer swaps one WIDTH-bit word
// in each direction. The serial nets are also copied to monitor outputs.
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on both sides
// (default build shifts MSB first; timing is the same in both builds).
module spi_link_pair #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             spi_slave_enable_i,
    input  logic [WIDTH-1:0] master_data_tx_i,
    input  logic [WIDTH-1:0] slave_data_tx_i,
    output logic             slave_data_enable_o,
    output logic [WIDTH-1:0] master_data_rx_o,
    output logic [WIDTH-1:0] slave_data_rx_o,
    output logic             sclk_o,
    output logic             ss_n_o,
    output logic             mosi_o,
    output logic             miso_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {M_IDLE, M_LOAD, M_SHIFT, M_DONE} masterState_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} slaveState_t;

    masterState_t r_masterState;
    masterState_t w_masterNext;
    slaveState_t  r_slaveState;
    slaveState_t  w_slaveNext;

    logic             w_slaveReady;
    logic             w_ssN;
    logic             w_strobe;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_miso;
    logic [CW-1:0]    r_masterCount;
    logic [CW-1:0]    r_slaveCount;
    logic [WIDTH-1:0] r_masterTx;
    logic [WIDTH-1:0] r_masterRx;
    logic [WIDTH-1:0] r_masterRxOut;
    logic [WIDTH-1:0] r_slaveTx;
    logic [WIDTH-1:0] r_slaveRx;
    logic [WIDTH-1:0] r_slaveRxOut;

    // Bit that goes on the wire first when a word is launched.
    function automatic logic firstBit(input logic [WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w[0];
`else
        return w[WIDTH-1];
`endif
    endfunction

    // Bit that goes on the wire after the current one has been sent.
    function automatic logic nextBit(input logic [WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w[1];
`else
        return w[WIDTH-2];
`endif
    endfunction

    // Drops the bit just sent from a transmit register.
    function automatic logic [WIDTH-1:0] shiftOut(input logic [WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        return {1'b0, w[WIDTH-1:1]};
`else
        return {w[WIDTH-2:0], 1'b0};
`endif
    endfunction

    // Appends a received bit so the finished word matches the sender's word.
    function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] w, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, w[WIDTH-1:1]};
`else
        return {w[WIDTH-2:0], b};
`endif
    endfunction

    assign w_slaveReady = spi_slave_enable_i && (r_slaveState == S_IDLE);

    // Master next-state logic; select and strobe decode straight from state.
    always_comb begin
        w_masterNext = r_masterState;
        w_ssN        = 1'b1;
        w_strobe     = 1'b0;
        case (r_masterState)
            M_IDLE:  if (w_slaveReady) w_masterNext = M_LOAD;
            M_LOAD:  begin
                w_ssN        = 1'b0;
                w_masterNext = M_SHIFT;
            end
            M_SHIFT: begin
                w_ssN = 1'b0;
                if (r_sclk && (r_masterCount == LAST_BIT)) w_masterNext = M_DONE;
            end
            M_DONE:  begin
                w_strobe     = 1'b1;
                w_masterNext = M_IDLE;
            end
            default: w_masterNext = M_IDLE;
        endcase
    end

    // Slave follows the master: it launches on the same edge and finishes
    // after counting the same number of SCLK falling edges.
    always_comb begin
        w_slaveNext = r_slaveState;
        case (r_slaveState)
            S_IDLE:  if (w_slaveReady) w_slaveNext = S_LOAD;
            S_LOAD:  w_slaveNext = S_SHIFT;
            S_SHIFT: if (r_sclk && (r_slaveCount == LAST_BIT)) w_slaveNext = S_DONE;
            S_DONE:  w_slaveNext = S_IDLE;
            default: w_slaveNext = S_IDLE;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_masterState <= M_IDLE;
            r_slaveState  <= S_IDLE;
        end else begin
            r_masterState <= w_masterNext;
            r_slaveState  <= w_slaveNext;
        end
    end

    // Master datapath: launch word, generate SCLK, sample MISO on rising
    // SCLK, present next MOSI bit on falling SCLK, publish word at the end.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_masterCount <= '0;
            r_masterTx    <= '0;
            r_masterRx    <= '0;
            r_masterRxOut <= '0;
        end else begin
            case (r_masterState)
                M_IDLE: begin
                    if (w_masterNext == M_LOAD) begin
                        r_masterTx    <= master_data_tx_i;
                        r_mosi        <= firstBit(master_data_tx_i);
                        r_masterCount <= '0;
                        r_sclk        <= 1'b0;
                    end
                end
                M_SHIFT: begin
                    if (!r_sclk) begin
                        r_sclk     <= 1'b1;
                        r_masterRx <= shiftIn(r_masterRx, r_miso);
                    end else begin
                        r_sclk        <= 1'b0;
                        r_masterTx    <= shiftOut(r_masterTx);
                        r_masterCount <= r_masterCount + CW'(1);
                        if (r_masterCount == LAST_BIT) begin
                            r_mosi        <= 1'b0;
                            r_masterRxOut <= r_masterRx;
                        end else begin
                            r_mosi <= nextBit(r_masterTx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Slave datapath: same edges as the master, driven by the shared SCLK.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_miso       <= 1'b0;
            r_slaveCount <= '0;
            r_slaveTx    <= '0;
            r_slaveRx    <= '0;
            r_slaveRxOut <= '0;
        end else begin
            case (r_slaveState)
                S_IDLE: begin
                    if (w_slaveNext == S_LOAD) begin
                        r_slaveTx    <= slave_data_tx_i;
                        r_miso       <= firstBit(slave_data_tx_i);
                        r_slaveCount <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!r_sclk) begin
                        r_slaveRx <= shiftIn(r_slaveRx, r_mosi);
                    end else begin
                        r_slaveTx    <= shiftOut(r_slaveTx);
                        r_slaveCount <= r_slaveCount + CW'(1);
                        if (r_slaveCount == LAST_BIT) begin
                            r_miso       <= 1'b0;
                            r_slaveRxOut <= r_slaveRx;
                        end else begin
                            r_miso <= nextBit(r_slaveTx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign slave_data_enable_o = w_strobe;
    assign master_data_rx_o    = r_masterRxOut;
    assign slave_data_rx_o     = r_slaveRxOut;
    assign sclk_o              = r_sclk;
    assign ss_n_o              = w_ssN;
    assign mosi_o              = r_mosi;
    assign miso_o              = r_miso;

endmodule

// File: tb/tb_spi_link_pair.sv
// tb_spi_link_pair: self-checking bench for spi_link_pair (WIDTH=8).
// Directed vector table, hand-written multi-cycle sequences and randomized
// transfers checked against a word-swap reference model.
`timescale 1ns/1ps
module tb_spi_link_pair;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] mtx;
    logic [W-1:0] stx;
    logic         strobe;
    logic [W-1:0] mrx;
    logic [W-1:0] srx;
    logic         sclk;
    logic         ssn;
    logic         mosi;
    logic         miso;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [W-1:0] mTx;
        logic [W-1:0] sTx;
        int           changeAt;
        logic [W-1:0] expMrx;
        logic [W-1:0] expSrx;
    } vec_t;

    spi_link_pair #(.WIDTH(W)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .spi_slave_enable_i  (en),
        .master_data_tx_i    (mtx),
        .slave_data_tx_i     (stx),
        .slave_data_enable_o (strobe),
        .master_data_rx_o    (mrx),
        .slave_data_rx_o     (srx),
        .sclk_o              (sclk),
        .ss_n_o              (ssn),
        .mosi_o              (mosi),
        .miso_o              (miso)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Order in which a word's bits should appear on the wire, first bit
    // ending up in the MSB position of the collected sequence.
    function automatic logic [W-1:0] wireOrder(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // A strobe must never be followed by another strobe on the next cycle.
    logic prevStrobe = 1'b0;
    always @(posedge clk) begin
        #1;
        if (prevStrobe) checkOutput("strobeOneCycle", 32'(strobe), 32'd0);
        prevStrobe = strobe;
    end

    // Starts one transfer with a single-cycle enable and watches it to the strobe.
    task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] s, input int changeAt,
                                 output int cycles, output int ssnLow, output int bits,
                                 output logic [W-1:0] mosiSeq, output logic [W-1:0] misoSeq);
        logic prevSclk;
        cycles   = -1;
        ssnLow   = 0;
        bits     = 0;
        mosiSeq  = '0;
        misoSeq  = '0;
        prevSclk = 1'b0;
        @(posedge clk); #1;
        mtx = m;
        stx = s;
        en  = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) en = 1'b0;
            if (n == changeAt) begin
                mtx = ~m;
                stx = ~s;
            end
            if (!ssn) ssnLow++;
            if (sclk && !prevSclk) begin
                bits++;
                mosiSeq = {mosiSeq[W-2:0], mosi};
                misoSeq = {misoSeq[W-2:0], miso};
            end
            prevSclk = sclk;
            if (strobe) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic doTransfer(input string name, input vec_t v);
        int cycles, ssnLow, bits;
        logic [W-1:0] mosiSeq, misoSeq;
        applyStimulus(v.mTx, v.sTx, v.changeAt, cycles, ssnLow, bits, mosiSeq, misoSeq);
        checkOutput({name, ".latency"}, 32'(cycles), 32'(2*W+2));
        checkOutput({name, ".ssnLowCycles"}, 32'(ssnLow), 32'(2*W+1));
        checkOutput({name, ".sclkRises"}, 32'(bits), 32'(W));
        checkOutput({name, ".masterRx"}, 32'(mrx), 32'(v.expMrx));
        checkOutput({name, ".slaveRx"}, 32'(srx), 32'(v.expSrx));
        checkOutput({name, ".mosiWire"}, 32'(mosiSeq), 32'(wireOrder(v.mTx)));
        checkOutput({name, ".misoWire"}, 32'(misoSeq), 32'(wireOrder(v.sTx)));
        checkOutput({name, ".ssnAtStrobe"}, 32'(ssn), 32'd1);
    endtask

    task automatic waitStrobe(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (strobe) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, ".strobe"}, 32'(strobe), 32'd0);
        checkOutput({name, ".masterRx"}, 32'(mrx), 32'd0);
        checkOutput({name, ".slaveRx"}, 32'(srx), 32'd0);
        checkOutput({name, ".sclk"}, 32'(sclk), 32'd0);
        checkOutput({name, ".ssn"}, 32'(ssn), 32'd1);
        checkOutput({name, ".mosi"}, 32'(mosi), 32'd0);
        checkOutput({name, ".miso"}, 32'(miso), 32'd0);
    endtask

    initial begin
        vec_t vectors[6];
        vec_t rv;
        int cycles;
        logic [W-1:0] expM, expS, savedM, savedS;
        int sclkHigh, ssnLowCnt, strobes;

        vectors[0] = '{8'hA5, 8'h3C, 0,  8'h3C, 8'hA5};
        vectors[1] = '{8'h5A, 8'hC3, 0,  8'hC3, 8'h5A};
        vectors[2] = '{8'h01, 8'h80, 0,  8'h80, 8'h01};
        vectors[3] = '{8'hFF, 8'h00, 0,  8'h00, 8'hFF};
        vectors[4] = '{8'h96, 8'h69, 5,  8'h69, 8'h96};
        vectors[5] = '{8'hC0, 8'h03, 12, 8'h03, 8'hC0};

        reset = 1'b1;
        en    = 1'b0;
        mtx   = '0;
        stx   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;

        // Directed vectors, including tx changes during the shift phase.
        for (int i = 0; i < 6; i++) doTransfer($sformatf("vec%0d", i), vectors[i]);

        // Back-to-back transfers with the enable held high.
        @(posedge clk); #1;
        mtx = 8'h01;
        stx = 8'h80;
        en  = 1'b1;
        waitStrobe(cycles);
        checkOutput("b2b0.latency", 32'(cycles), 32'(2*W+2));
        checkOutput("b2b0.masterRx", 32'(mrx), 32'h80);
        checkOutput("b2b0.slaveRx", 32'(srx), 32'h01);
        mtx = 8'hFF;
        stx = 8'h00;
        waitStrobe(cycles);
        checkOutput("b2b1.period", 32'(cycles), 32'(2*W+3));
        checkOutput("b2b1.masterRx", 32'(mrx), 32'h00);
        checkOutput("b2b1.slaveRx", 32'(srx), 32'hFF);
        mtx = 8'h33;
        stx = 8'hCC;
        waitStrobe(cycles);
        checkOutput("b2b2.period", 32'(cycles), 32'(2*W+3));
        checkOutput("b2b2.masterRx", 32'(mrx), 32'hCC);
        checkOutput("b2b2.slaveRx", 32'(srx), 32'h33);
        en = 1'b0;

        // Enable low: bus stays idle and received words hold.
        savedM    = mrx;
        savedS    = srx;
        sclkHigh  = 0;
        ssnLowCnt = 0;
        strobes   = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (sclk) sclkHigh++;
            if (!ssn) ssnLowCnt++;
            if (strobe) strobes++;
        end
        checkOutput("idle.sclkHigh", 32'(sclkHigh), 32'd0);
        checkOutput("idle.ssnLow", 32'(ssnLowCnt), 32'd0);
        checkOutput("idle.strobes", 32'(strobes), 32'd0);
        checkOutput("idle.masterRxHold", 32'(mrx), 32'(savedM));
        checkOutput("idle.slaveRxHold", 32'(srx), 32'(savedS));

        // Reset during the fifth shift cycle.
        @(posedge clk); #1;
        mtx = 8'h11;
        stx = 8'h22;
        en  = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n == 1) en = 1'b0;
        end
        checkOutput("midReset.busy", 32'(ssn), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkIdleOutputs("midReset");
        reset = 1'b0;
        rv = '{8'h5A, 8'hC3, 0, 8'hC3, 8'h5A};
        doTransfer("afterReset", rv);

        // Randomized transfers against the word-swap model.
        for (int i = 0; i < 20; i++) begin
            rv.mTx      = W'($urandom);
            rv.sTx      = W'($urandom);
            rv.changeAt = int'($urandom_range(0, 2*W+1));
            expM        = rv.sTx;
            expS        = rv.mTx;
            rv.expMrx   = expM;
            rv.expSrx   = expS;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            doTransfer($sformatf("rand%0d", i), rv);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
